// File: rtl/ctrl_pool_store_pkg.sv
// ctrl_pool_store_pkg: shared widths, FSM states and ctrl bus record for the pool store stage.
package ctrl_pool_store_pkg;
    localparam int DWIDTH = 16;
    localparam int AWIDTH = 12;
    localparam int LWIDTH = 10;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_MAP, S_RECV, S_DONE} state_t;

    typedef struct packed {
        logic start;
        logic valid;
        logic stop;
    } ctrl_reg;
endpackage

// File: rtl/ctrl_bus.sv
// ctrl_bus: start/valid/stop handshake between datapath stages.
interface ctrl_bus;
    logic start;
    logic valid;
    logic stop;
    modport in (input start, valid, stop);
    modport out (output start, valid, stop);
endinterface

// File: rtl/ctrl_pool_store_addr.sv
// pool_store_addr: write pointer plus map/pixel counters for one output layer.
// Pixel counting and pix_total exist only with CTRL_POOL_STORE_CHECK_EN.
module pool_store_addr #(
    parameter int AWIDTH = ctrl_pool_store_pkg::AWIDTH,
    parameter int LWIDTH = ctrl_pool_store_pkg::LWIDTH
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              load,
    input  logic [AWIDTH-1:0] base,
    input  logic [LWIDTH-1:0] n_map,
`ifdef CTRL_POOL_STORE_CHECK_EN
    input  logic [LWIDTH-1:0] size,
    output logic              pix_match,
`endif
    input  logic              clr,
    input  logic              inc,
    input  logic              map_inc,
    output logic [AWIDTH-1:0] addr,
    output logic              map_last
);
    logic [LWIDTH-1:0] n_reg;
    logic [LWIDTH-1:0] map_cnt;

    always_ff @(posedge clk) begin
        if (!xrst) begin
            addr    <= '0;
            n_reg   <= '0;
            map_cnt <= '0;
        end else if (load) begin
            addr    <= base;
            n_reg   <= n_map;
            map_cnt <= '0;
        end else begin
            if (inc) addr <= addr + AWIDTH'(1);
            if (map_inc) map_cnt <= map_cnt + LWIDTH'(1);
        end
    end

    assign map_last = map_cnt == n_reg - LWIDTH'(1);

`ifdef CTRL_POOL_STORE_CHECK_EN
    logic [2*LWIDTH-1:0] pix_total;
    logic [2*LWIDTH-1:0] pix_cnt;
    logic [2*LWIDTH-1:0] pix_next;

    // count including the pixel presented this cycle, so stop+valid compares the final total
    assign pix_next  = (clr ? '0 : pix_cnt) + (2*LWIDTH)'(inc);
    assign pix_match = pix_next == pix_total;

    always_ff @(posedge clk) begin
        if (!xrst) begin
            pix_total <= '0;
            pix_cnt   <= '0;
        end else if (load) begin
            pix_total <= (2*LWIDTH)'(size) * (2*LWIDTH)'(size);
            pix_cnt   <= '0;
        end else begin
            pix_cnt <= pix_next;
        end
    end
`endif
endmodule

// File: rtl/ctrl_pool_store.sv
// ctrl_pool_store: turns the pooled ctrl_bus stream into output memory writes and a layer ack.
// Optional protocol checking (sticky err) is enabled by CTRL_POOL_STORE_CHECK_EN.
module ctrl_pool_store #(
    parameter int DWIDTH = ctrl_pool_store_pkg::DWIDTH,
    parameter int AWIDTH = ctrl_pool_store_pkg::AWIDTH,
    parameter int LWIDTH = ctrl_pool_store_pkg::LWIDTH
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              req,
    input  logic [AWIDTH-1:0] out_base,
    input  logic [LWIDTH-1:0] out_size,
    input  logic [LWIDTH-1:0] n_map,
    ctrl_bus.in               in_ctrl,
    input  logic [DWIDTH-1:0] pool_data,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              busy,
    output logic              ack,
    output logic              err
);
    import ctrl_pool_store_pkg::*;

    state_t            state;
    state_t            state_n;
    ctrl_reg           c;
    logic              load;
    logic              acc;
    logic              wr;
    logic              fin;
    logic              clr;
    logic              map_last;
    logic [AWIDTH-1:0] addr;

    assign c    = '{start: in_ctrl.start, valid: in_ctrl.valid, stop: in_ctrl.stop};
    assign load = req && state == S_IDLE;
    // a start in S_WAIT_MAP opens the map in the same cycle, so its valid/stop count
    assign acc  = state == S_RECV || (state == S_WAIT_MAP && c.start);
    assign wr   = acc && c.valid;
    assign fin  = acc && c.stop;
    assign clr  = state == S_WAIT_MAP && c.start;
    assign busy = state != S_IDLE;

    always_comb begin
        state_n = state;
        if (load) state_n = n_map == '0 ? S_DONE : S_WAIT_MAP;
        else if (fin) state_n = map_last ? S_DONE : S_WAIT_MAP;
        else if (clr) state_n = S_RECV;
        else if (state == S_DONE) state_n = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ack       <= 1'b0;
        end else begin
            state  <= state_n;
            mem_we <= wr;
            ack    <= state == S_DONE;
            if (wr) begin
                mem_addr  <= addr;
                mem_wdata <= pool_data;
            end
        end
    end

`ifdef CTRL_POOL_STORE_CHECK_EN
    logic pix_match;
    logic proto;

    assign proto = (state == S_WAIT_MAP && c.valid && !c.start) || (state == S_RECV && c.start) || (fin && !pix_match);

    always_ff @(posedge clk) begin
        if (!xrst) err <= 1'b0;
        else if (load) err <= 1'b0;
        else if (proto) err <= 1'b1;
    end
`else
    logic unused_size;
    assign unused_size = ^out_size;
    assign err = 1'b0;
`endif

    pool_store_addr #(.AWIDTH(AWIDTH), .LWIDTH(LWIDTH)) u_addr (
        .clk      (clk),
        .xrst     (xrst),
        .load     (load),
        .base     (out_base),
        .n_map    (n_map),
`ifdef CTRL_POOL_STORE_CHECK_EN
        .size     (out_size),
        .pix_match(pix_match),
`endif
        .clr      (clr),
        .inc      (wr),
        .map_inc  (fin),
        .addr     (addr),
        .map_last (map_last)
    );
endmodule

// File: tb/tb_ctrl_pool_store.sv
// tb_ctrl_pool_store: directed vectors against a layer-level write/ack/err model.
module tb_ctrl_pool_store;
`ifdef CTRL_POOL_STORE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        xrst = 1'b0;
    logic        req = 1'b0;
    logic [11:0] out_base = '0;
    logic [9:0]  out_size = '0;
    logic [9:0]  n_map = '0;
    logic [15:0] pool_data = '0;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        ack;
    logic        err;

    ctrl_bus bus ();

    ctrl_pool_store dut (
        .clk      (clk),
        .xrst     (xrst),
        .req      (req),
        .out_base (out_base),
        .out_size (out_size),
        .n_map    (n_map),
        .in_ctrl  (bus),
        .pool_data(pool_data),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .ack      (ack),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          c;
        logic [11:0] a;
        logic [15:0] d;
    } wr_t;

    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   acks = 0;
    int   last_ack_c = 0;
    bit   chk_on = 1'b0;
    wr_t  wq[$];
    wr_t  wlog[$];
    int   ack_at[$];
    int   b_on = 0;
    int   b_off = 0;
    logic err_old = 1'b0;
    logic err_new = 1'b0;
    int   err_c = 0;

    // layer-level model state: progress counted in pixels and maps, not FSM states
    bit   m_on = 1'b0;
    bit   m_rx = 1'b0;
    int   m_free = 0;
    int   m_base, m_pix, m_n, m_ptr, m_maps, m_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    task automatic chk_log(input int i, input logic [11:0] a, input logic [15:0] d);
        if (i >= wlog.size()) chk("wlog_index", i, wlog.size());
        else begin
            chk("wlog_addr", wlog[i].a, a);
            chk("wlog_data", wlog[i].d, d);
        end
    endtask

    task automatic err_set(input logic v, input int c);
        err_old = (cyc >= err_c) ? err_new : err_old;
        err_new = v;
        err_c = c;
    endtask

    task automatic model(input logic r, input logic s, input logic v, input logic p, input logic [15:0] d);
        int n;
        bit acc;
        bit bad;
        n = cyc + 1;
        bad = 1'b0;
        if (r && cyc >= m_free) begin
            m_base = int'(out_base);
            m_pix = int'(out_size) * int'(out_size);
            m_n = int'(n_map);
            m_ptr = 0;
            m_maps = 0;
            b_on = n;
            err_set(1'b0, n);
            if (m_n == 0) begin
                ack_at.push_back(n + 1);
                b_off = n + 1;
                m_free = n + 1;
            end else begin
                m_on = 1'b1;
                m_rx = 1'b0;
                b_off = 1 << 30;
                m_free = 1 << 30;
            end
        end else if (m_on) begin
            acc = m_rx || s;
            bad = (!m_rx && v && !s) || (m_rx && s);
            if (!m_rx && s) m_cnt = 0;
            if (s) m_rx = 1'b1;
            if (acc && v) begin
                wq.push_back('{n, 12'(m_base + m_ptr), d});
                m_ptr++;
                m_cnt++;
            end
            if (acc && p) begin
                if (m_cnt != m_pix) bad = 1'b1;
                m_maps++;
                m_rx = 1'b0;
                if (m_maps == m_n) begin
                    m_on = 1'b0;
                    ack_at.push_back(n + 1);
                    b_off = n + 1;
                    m_free = n + 1;
                end
            end
            if (CHK && bad) err_set(1'b1, n);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic v, input logic p, input logic [15:0] d);
        @(posedge clk);
        #1;
        req = r;
        bus.start = s;
        bus.valid = v;
        bus.stop = p;
        pool_data = d;
        model(r, s, v, p, d);
    endtask

    task automatic idle(input int k);
        repeat (k) drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic start_layer(input logic [11:0] b, input logic [9:0] sz, input logic [9:0] nm);
        out_base = b;
        out_size = sz;
        n_map = nm;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic do_reset();
        int n;
        wr_t keep[$];
        int  keep_a[$];
        @(posedge clk);
        #1;
        xrst = 1'b0;
        req = 1'b0;
        bus.start = 1'b0;
        bus.valid = 1'b0;
        bus.stop = 1'b0;
        n = cyc + 1;
        foreach (wq[i]) if (wq[i].c < n) keep.push_back(wq[i]);
        wq = keep;
        foreach (ack_at[i]) if (ack_at[i] < n) keep_a.push_back(ack_at[i]);
        ack_at = keep_a;
        if (b_off > n) b_off = n;
        err_set(1'b0, n);
        m_on = 1'b0;
        m_free = n;
        @(posedge clk);
        #1;
        xrst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            logic ew;
            logic ea;
            ew = wq.size() > 0 && wq[0].c == cyc;
            chk("mem_we", mem_we, ew);
            if (mem_we) wlog.push_back('{cyc, mem_addr, mem_wdata});
            if (ew) begin
                chk("mem_addr", mem_addr, wq[0].a);
                chk("mem_wdata", mem_wdata, wq[0].d);
                void'(wq.pop_front());
            end
            ea = ack_at.size() > 0 && ack_at[0] == cyc;
            chk("ack", ack, ea);
            if (ack) begin
                acks++;
                last_ack_c = cyc;
            end
            if (ea) void'(ack_at.pop_front());
            chk("busy", busy, cyc >= b_on && cyc < b_off);
            chk("err", err, (cyc >= err_c) ? err_new : err_old);
        end
    end

    initial begin
        int t0;
        int t1;
        bus.start = 1'b0;
        bus.valid = 1'b0;
        bus.stop = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 12'h0);
        chk("rst_mem_wdata", mem_wdata, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", ack, 1'b0);
        chk("rst_err", err, 1'b0);
        xrst = 1'b1;
        chk_on = 1'b1;
        idle(2);

        // single map, 1 cycle write latency, ack one cycle after the final write
        wlog.delete();
        acks = 0;
        start_layer(12'h100, 10'd2, 10'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
        t0 = cyc;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'd3);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'd4);
        t1 = cyc;
        idle(4);
        chk("t1_nwrites", wlog.size(), 4);
        chk_log(0, 12'h100, 16'd1);
        chk_log(3, 12'h103, 16'd4);
        if (wlog.size() > 0) chk("t1_latency", wlog[0].c, t0 + 1);
        chk("t1_acks", acks, 1);
        chk("t1_ack_cycle", last_ack_c, t1 + 2);

        // three maps with idle gaps, contiguous addresses; a req mid-layer is ignored
        wlog.delete();
        acks = 0;
        start_layer(12'h000, 10'd3, 10'd3);
        for (int m = 0; m < 3; m++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
            for (int i = 0; i < 9; i++) begin
                drive(1'b0, 1'b0, 1'b1, i == 8, 16'(16'h50 + m * 9 + i));
                if (i % 3 == 2 && i != 8) idle(1);
                if (m == 1 && i == 4) start_layer(12'h800, 10'd1, 10'd1);
            end
            idle(2);
        end
        idle(2);
        chk("t2_nwrites", wlog.size(), 27);
        chk_log(9, 12'h009, 16'h59);
        chk_log(26, 12'h01A, 16'h6A);
        chk("t2_acks", acks, 1);

        // address wrap at the top of memory
        wlog.delete();
        start_layer(12'hFFE, 10'd2, 10'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, i == 3, 16'(16'hA0 + i));
        idle(3);
        chk_log(0, 12'hFFE, 16'hA0);
        chk_log(1, 12'hFFF, 16'hA1);
        chk_log(2, 12'h000, 16'hA2);
        chk_log(3, 12'h001, 16'hA3);

        // start+valid together, valid+stop together, then a zero-map layer right after ack
        wlog.delete();
        acks = 0;
        start_layer(12'h300, 10'd1, 10'd2);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'hAA);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'hBB);
        t1 = cyc;
        idle(2);
        chk("t4_ack_now", ack, 1'b1);
        start_layer(12'h400, 10'd1, 10'd0);
        idle(4);
        chk("t4_nwrites", wlog.size(), 2);
        chk_log(0, 12'h300, 16'hAA);
        chk_log(1, 12'h301, 16'hBB);
        chk("t4_acks", acks, 2);

        // short map (3 of 4 pixels), then a valid before start
        wlog.delete();
        start_layer(12'h500, 10'd2, 10'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, i == 2, 16'(16'hC0 + i));
        idle(4);
        chk("t5_err_short", err, CHK);
        start_layer(12'h600, 10'd2, 10'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h77);
        idle(1);
        chk("t5_err_early", err, CHK);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, i == 3, 16'(16'hD0 + i));
        idle(3);
        chk("t5_nwrites", wlog.size(), 7);
        chk_log(3, 12'h600, 16'hD0);
        chk("t5_err_held", err, CHK);

        // reset mid-layer aborts without ack; the next layer runs normally
        wlog.delete();
        acks = 0;
        start_layer(12'h700, 10'd2, 10'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'hE0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'hE1);
        do_reset();
        chk("t6_rst_we", mem_we, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_err", err, 1'b0);
        idle(3);
        chk("t6_acks_abort", acks, 0);
        start_layer(12'h710, 10'd2, 10'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, i == 3, 16'(16'hF0 + i));
        idle(4);
        chk("t6_nwrites", wlog.size(), 6);
        chk_log(2, 12'h710, 16'hF0);
        chk_log(5, 12'h713, 16'hF3);
        chk("t6_acks", acks, 1);

        chk("model_drained", wq.size() + ack_at.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
